// File: rtl/meas_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : meas_wr_arbiter
// Brief    : Collects per-channel measure results into holding registers and
//            serialises them round-robin onto one valid/ready write port,
//            flagging and counting results overwritten before forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module meas_wr_arbiter #(
    parameter int CHANNELS   = 5,
    parameter int DATA_WIDTH = 64,
    parameter int CHAN_WIDTH = $clog2(CHANNELS)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [CHANNELS-1:0]            raw_wr_en_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] raw_wr_data_i,
    input  logic                           reg_wr_rdy_i,
    input  logic                           ovf_clr_i,
    output logic                           reg_wr_vld_o,
    output logic [DATA_WIDTH-1:0]          reg_wr_data_o,
    output logic [CHAN_WIDTH-1:0]          reg_wr_chan_o,
    output logic [CHANNELS-1:0]            ovf_o,
    output logic [15:0]                    ovf_cnt_o
);

    localparam int c_EVT_W = $clog2(CHANNELS + 1);

    logic [CHANNELS*DATA_WIDTH-1:0] w_hold_flat;
    logic [CHANNELS-1:0]            r_pend;
    logic [CHAN_WIDTH-1:0]          r_ptr;
    logic                           r_vld;
    logic [DATA_WIDTH-1:0]          r_data;
    logic [CHAN_WIDTH-1:0]          r_chan;
    logic [CHANNELS-1:0]            r_ovf;
    logic [15:0]                    r_ovf_cnt;

    logic                           w_free;
    logic                           w_gnt_any;
    logic [CHAN_WIDTH-1:0]          w_gnt_idx;
    logic                           w_grant;
    logic [CHANNELS-1:0]            w_gnt_oh;
    logic [CHANNELS-1:0]            w_ovr;
    logic [c_EVT_W-1:0]             w_evt_cnt;
    logic [16:0]                    w_cnt_sum;
    logic [DATA_WIDTH-1:0]          w_gnt_data;

    // Channel index addition modulo CHANNELS (CHANNELS need not be a power of two)
    function automatic logic [CHAN_WIDTH-1:0] wrap_add(
        input logic [CHAN_WIDTH-1:0] base,
        input int                    off
    );
        logic [CHAN_WIDTH:0] s;
        s = {1'b0, base} + (CHAN_WIDTH+1)'(off);
        if (s >= (CHAN_WIDTH+1)'(CHANNELS))
            s = s - (CHAN_WIDTH+1)'(CHANNELS);
        return s[CHAN_WIDTH-1:0];
    endfunction

    assign w_free = ~r_vld | reg_wr_rdy_i;

    // Scan from the farthest offset down so the nearest pending channel wins
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_pend[wrap_add(r_ptr, i)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = wrap_add(r_ptr, i);
            end
        end
    end

    assign w_grant    = w_free & w_gnt_any;
    assign w_gnt_oh   = w_grant ? (CHANNELS'(1) << w_gnt_idx) : '0;
    assign w_gnt_data = w_hold_flat[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // A strobe on a still-pending channel loses the old word unless it is leaving this cycle
    assign w_ovr = raw_wr_en_i & r_pend & ~w_gnt_oh;

    always_comb begin
        w_evt_cnt = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_evt_cnt = w_evt_cnt + c_EVT_W'(w_ovr[k]);
    end

    assign w_cnt_sum = {1'b0, r_ovf_cnt} + 17'(w_evt_cnt);

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            logic [DATA_WIDTH-1:0] r_hold;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    r_hold <= '0;
                else if (raw_wr_en_i[k])
                    r_hold <= raw_wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end

            assign w_hold_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_hold;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_pend <= '0;
        else
            r_pend <= raw_wr_en_i | (r_pend & ~w_gnt_oh);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_chan <= '0;
            r_ptr  <= '0;
        end else if (w_free) begin
            r_vld <= w_gnt_any;
            if (w_gnt_any) begin
                r_data <= w_gnt_data;
                r_chan <= w_gnt_idx;
                r_ptr  <= wrap_add(w_gnt_idx, 1);
            end
        end
    end

    // New overruns take precedence over a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ovf     <= '0;
            r_ovf_cnt <= '0;
        end else if (ovf_clr_i) begin
            r_ovf     <= w_ovr;
            r_ovf_cnt <= 16'(w_evt_cnt);
        end else begin
            r_ovf     <= r_ovf | w_ovr;
            r_ovf_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign reg_wr_vld_o  = r_vld;
    assign reg_wr_data_o = r_data;
    assign reg_wr_chan_o = r_chan;
    assign ovf_o         = r_ovf;
    assign ovf_cnt_o     = r_ovf_cnt;

endmodule
`default_nettype wire
